// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: ALU opcodes, controller states and
// the bit positions of the NZCV flags.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_ORR = 3'd3,
    OP_EOR = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Start/done handshake between the multi-cycle controller (master) and the
// execute unit (slave), including operands and the registered result.
interface alu_seq_if #(parameter int WIDTH = 8);
  import cpu_pkg::*;

  logic             start;
  alu_op_t          op;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, op, rd1, rd2,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, op, rd1, rd2,
    output busy, done, result, flags
  );

endinterface

// File: rtl/mul8_seq.sv
// 8x8 shift-add multiplier: loaded by start_i, then adds one partial product
// per cycle for exactly 8 cycles while busy_o is high.
module mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        busy_o,
  output logic [15:0] product_o
);

  logic [15:0] acc_q,    acc_d;
  logic [15:0] mcand_q,  mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic        run_q,    run_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      acc_d    = 16'h0000;
      mcand_d  = {8'h00, a_i};
      mplier_d = b_i;
      cnt_d    = 3'd0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = {mcand_q[14:0], 1'b0};
      mplier_d = {1'b0, mplier_q[7:1]};
      cnt_d    = cnt_q + 3'd1;
      // The counter wraps on the eighth step, which is also the last one.
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      cnt_q    <= 3'd0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign busy_o    = run_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute unit: latches operands on start, runs single-cycle,
// iterative shift or shift-add multiply ops, and returns result + NZCV.
module alu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  alu_state_t       state_q,  state_d;
  alu_op_t          op_q,     op_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       cnt_q,    cnt_d;
  logic             c_q,      c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q,  flags_d;
  logic             done_q,   done_d;

  logic             mul_start;
  logic             mul_busy;
  logic [15:0]      mul_product;

  logic [WIDTH:0]   sum9;
  logic [WIDTH:0]   diff9;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_v;
  logic [3:0]       fin_flags;

  mul8_seq u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (bus.rd1),
    .b_i       (bus.rd2),
    .busy_o    (mul_busy),
    .product_o (mul_product)
  );

  // Final result and flags, evaluated from the latched operands in FIN.
  always_comb begin
    sum9    = {1'b0, a_q} + {1'b0, b_q};
    diff9   = {1'b0, a_q} - {1'b0, b_q};
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        fin_res = sum9[WIDTH-1:0];
        fin_c   = sum9[WIDTH];
        fin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum9[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        fin_res = diff9[WIDTH-1:0];
        fin_c   = ~diff9[WIDTH];
        fin_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff9[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: fin_res = a_q & b_q;
      OP_ORR: fin_res = a_q | b_q;
      OP_EOR: fin_res = a_q ^ b_q;
      OP_LSL, OP_LSR: begin
        fin_res = a_q;
        fin_c   = c_q;
      end
      OP_MUL: begin
        fin_res = mul_product[WIDTH-1:0];
        fin_c   = |mul_product[2*WIDTH-1:WIDTH];
      end
      default: fin_res = '0;
    endcase
    fin_flags = pack_flags(fin_res[WIDTH-1], fin_res == '0, fin_c, fin_v);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    result_d  = result_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d       = bus.rd1;
          b_d       = bus.rd2;
          op_d      = bus.op;
          c_d       = 1'b0;
          cnt_d     = (bus.op == OP_LSL || bus.op == OP_LSR) ? bus.rd2[2:0] : 3'd0;
          mul_start = (bus.op == OP_MUL);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unique case (op_q)
          OP_LSL, OP_LSR: begin
            if (cnt_q == 3'd0) begin
              state_d = ST_FIN;
            end else begin
              cnt_d = cnt_q - 3'd1;
              if (op_q == OP_LSL) begin
                c_d = a_q[WIDTH-1];
                a_d = {a_q[WIDTH-2:0], 1'b0};
              end else begin
                c_d = a_q[0];
                a_d = {1'b0, a_q[WIDTH-1:1]};
              end
            end
          end
          OP_MUL: begin
            if (!mul_busy) begin
              state_d = ST_FIN;
            end
          end
          default: state_d = ST_FIN;
        endcase
      end
      ST_FIN: begin
        result_d = fin_res;
        flags_d  = fin_flags;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= 3'd0;
      c_q      <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural model predicts result, flags
// and latency at issue time; a monitor pops and compares on every done.
module tb_alu_seq;
  import cpu_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
    int         acc;
    string      tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];
  logic [7:0] last_res = 8'h00;
  logic [3:0] last_flg = 4'h0;

  alu_seq_if #(.WIDTH(8)) bus();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic [3:0] flg, output int lat);
    int ua   = int'(a);
    int ub   = int'(b);
    int sa   = int'($signed(a));
    int sbv  = int'($signed(b));
    int k    = int'(b[2:0]);
    int full = 0;
    int sres = 0;
    bit c    = 1'b0;
    bit v    = 1'b0;
    lat = 2;
    case (op)
      OP_ADD: begin full = ua + ub; c = (full > 255); sres = sa + sbv; v = (sres > 127) || (sres < -128); end
      OP_SUB: begin full = ua - ub; c = (ua >= ub); sres = sa - sbv; v = (sres > 127) || (sres < -128); end
      OP_AND: full = ua & ub;
      OP_ORR: full = ua | ub;
      OP_EOR: full = ua ^ ub;
      OP_LSL: begin full = ua << k; c = (k != 0) && (((ua >> (8 - k)) & 1) != 0); lat = k + 2; end
      OP_LSR: begin full = ua >> k; c = (k != 0) && (((ua >> (k - 1)) & 1) != 0); lat = k + 2; end
      default: begin full = ua * ub; c = (full > 255); lat = 10; end
    endcase
    res = full[7:0];
    flg = {res[7], (res == 8'h00), c, v};
  endfunction

  // Drive one request at a falling edge; it is accepted at the next rising edge.
  task automatic issue(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input string tag);
    exp_t e;
    logic [7:0] r;
    logic [3:0] f;
    int l;
    model(op, a, b, r, f, l);
    e.res = r; e.flg = f; e.lat = l; e.acc = cyc + 1; e.tag = tag;
    bus.start = 1'b1; bus.op = op; bus.rd1 = a; bus.rd2 = b;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Scramble the operand bus and re-strobe start while a multiply is running.
  task automatic disturb();
    repeat (3) @(negedge clk);
    bus.rd1 = 8'($urandom_range(255));
    bus.rd2 = 8'($urandom_range(255));
    bus.op = OP_ADD;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rd1 = 8'($urandom_range(255));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_res = 8'h00;
        last_flg = 4'h0;
      end else if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_res"}, 32'(bus.result), 32'(e.res));
          chk({e.tag, "_flags"}, 32'(bus.flags), 32'(e.flg));
          chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
          $display("[TB] %s result=%02h flags=%b latency=%0d", e.tag, bus.result, bus.flags, cyc - e.acc);
        end
        last_res = bus.result;
        last_flg = bus.flags;
      end else if (bus.busy) begin
        chk("hold_result", {20'd0, bus.flags, bus.result}, {20'd0, last_flg, last_res});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = OP_ADD; bus.rd1 = 8'h00; bus.rd2 = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 8'h7F, 8'h01, "add_ovf");   wait_drain();
    issue(OP_ADD, 8'hFF, 8'h01, "add_carry"); wait_drain();
    issue(OP_SUB, 8'h05, 8'h07, "sub_neg");   wait_drain();
    issue(OP_SUB, 8'h07, 8'h07, "sub_zero");  wait_drain();
    issue(OP_LSL, 8'h81, 8'h01, "lsl_k1");    wait_drain();
    issue(OP_LSR, 8'h81, 8'h00, "lsr_k0");    wait_drain();
    issue(OP_LSR, 8'h80, 8'h07, "lsr_k7");    wait_drain();

    issue(OP_ORR, 8'hF0, 8'h0F, "orr");
    for (int i = 0; i < 10 && !bus.done; i++) @(negedge clk);
    issue(OP_EOR, 8'hFF, 8'hFF, "eor_b2b");
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      issue(alu_op_t'(3'($urandom_range(7))), 8'($urandom_range(255)), 8'($urandom_range(255)), "rand");
      wait_drain();
    end

    issue(OP_MUL, 8'h10, 8'h11, "mul_carry"); disturb(); wait_drain();
    issue(OP_MUL, 8'h0F, 8'h11, "mul_ff");    disturb(); wait_drain();

    issue(OP_MUL, 8'h10, 8'h11, "mul_abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_flags", 32'(bus.flags), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    issue(OP_ADD, 8'h01, 8'h01, "add_after_rst");
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle 8-bit execute unit sitting directly downstream of the register file: it latches the two read-port operands (RD1, RD2) on a start strobe, evaluates one of eight operations, and returns an 8-bit result plus NZCV flags that the controller writes back through the register-file write port. Single-cycle logic/arithmetic ops, iterative shifts and an 8-cycle shift-add multiply share one start/done handshake driven by the multi-cycle controller.

## Interface
- `WIDTH`, 8: operand/result width. Only 8 is supported.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin operation; sampled only in IDLE.
- `op` input 3: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 LSL, 6 LSR, 7 MUL.
- `rd1` input 8: operand A, from register-file read port 1.
- `rd2` input 8: operand B, from register-file read port 2. For shifts only `rd2[2:0]` is used, as the shift amount k.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; `result`/`flags` valid from this cycle.
- `result` output 8: registered result; holds until the next `done`.
- `flags` output 4: {N,Z,C,V}, registered; updates only with `done`.

## Operation
- States: IDLE, EXEC, FIN.
  - IDLE & start: latch A=rd1, B=rd2, op; set the iteration counter; go to EXEC.
  - EXEC: iterate until the counter expires, then go to FIN.
  - FIN: write `result`/`flags`, pulse `done`, return to IDLE.
- `start` while not IDLE is ignored; the latched operands are unaffected.
- Operand latch: `rd1`/`rd2` are sampled only at the accepting edge. Later register-file writes do not disturb an operation in flight.
- ADD/SUB/AND/ORR/EOR:
  - zero EXEC iterations.
  - 9-bit arithmetic; result = low 8 bits.
- LSL/LSR: one bit per EXEC cycle, k iterations (k = 0..7); zero-fill.
- MUL: 8 EXEC iterations of a shift-add into a 16-bit accumulator; result = product[7:0].
- N = result[7]; Z = (result == 0).
- C by op:
  - ADD: carry out.
  - SUB: not-borrow, i.e. 1 when A ≥ B unsigned.
  - LSL/LSR: last bit shifted out; 0 when k = 0.
  - MUL: 1 when product[15:8] ≠ 0.
  - logic ops: 0.
- V: signed overflow for ADD/SUB; 0 for all other ops.
- Reset (any state, asynchronous):
  - state goes to IDLE; `busy`, `done` = 0; `result` = 0x00; `flags` = 0000.
  - An operation in flight is abandoned; no `done` is issued for it.

## Timing
- Start accepted at edge 0 (start=1, IDLE).
- `busy` = 1 from after edge 0 until after the edge that enters FIN → IDLE.
  - `busy` is high in EXEC and FIN.
  - `busy` is low in the `done` cycle following FIN.
- `done` and new `result`/`flags` appear after edge n+2:
  - Single-cycle ops: n = 0, so `done` follows edge 2 (latency 2).
  - Shifts: n = k, so latency k+2.
  - MUL: n = 8, so latency 10.
- Back-to-back: `start` may be asserted in the same cycle `done` is high. It is accepted at that edge, since the unit is in IDLE.
- `result`/`flags` are stable across the whole busy window of the next operation.

## Structure
- Shared package `cpu_pkg`:
  - `alu_op_t` enum (3-bit encodings above).
  - `alu_state_t` enum.
  - flag bit-index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- One sub-module, `mul8_seq`: 16-bit accumulator, multiplicand shift register, 3-bit counter. Started by `alu_seq` and reports completion after 8 cycles.
- Shifts and single-cycle ops stay in `alu_seq`.

## Test plan
- ADD rd1=0x7F, rd2=0x01 → `done` at latency 2, result 0x80, flags N=1 Z=0 C=0 V=1. Then ADD 0xFF+0x01 → 0x00, N=0 Z=1 C=1 V=0.
- SUB 0x05−0x07 → result 0xFE, N=1 Z=0 C=0 V=0. Then SUB 0x07−0x07 → 0x00, Z=1 C=1.
- LSL 0x81 by k=1 → latency 3, result 0x02, C=1. LSR 0x81 by k=0 → latency 2, result 0x81, C=0. LSR 0x80 by k=7 → latency 9, result 0x01, C=0.
- MUL 0x10×0x11 → latency 10, result 0x10, C=1. MUL 0x0F×0x11 → 0xFF, N=1, C=0. During each MUL, change rd1/rd2 and pulse `start` mid-operation → ignored; result unchanged.
- Back-to-back: ORR 0xF0|0x0F, then `start` EOR 0xFF^0xFF in the `done` cycle → results 0xFF then 0x00 (Z=1), with no idle gap.
- Assert `rst_n`=0 at MUL iteration 4 → `busy`, `done`, `result`, `flags` all 0 immediately. No `done` after release. The next ADD 0x01+0x01 returns 0x02 at latency 2.
